// File: rtl/tlu_event_packer_if.sv
// Bus interface for tlu_event_packer: upstream 16-bit FIFO read port and
// downstream 32-bit valid/ready word stream. The master modport is the packer
// side; the slave modport is the surrounding FIFO/consumer side.
interface tlu_event_packer_if;
    logic        SRC_EMPTY;
    logic [15:0] SRC_DATA;
    logic        SRC_READ;
    logic [31:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_LAST;
    logic        OUT_READY;

    modport master (
        input  SRC_EMPTY,
        input  SRC_DATA,
        input  OUT_READY,
        output SRC_READ,
        output OUT_DATA,
        output OUT_VALID,
        output OUT_LAST
    );

    modport slave (
        output SRC_EMPTY,
        output SRC_DATA,
        output OUT_READY,
        input  SRC_READ,
        input  OUT_DATA,
        input  OUT_VALID,
        input  OUT_LAST
    );
endinterface

// File: rtl/tlu_event_packer.sv
// tlu_event_packer: collects eight 16-bit TLU words from the upstream FIFO into
// a single event buffer, then emits them as four 32-bit words (last flagged).
// Optional trigger-ID continuity check: define TLU_EVENT_PACKER_ID_CHECK_EN.
// Without it, ID_ERR and ID_ERR_CNT are tied to zero.
module tlu_event_packer #(
    parameter int unsigned EVENT_CNT_WIDTH = 16
) (
    input  logic                       BUS_CLK,
    input  logic                       RST,
    tlu_event_packer_if.master         bus,
    output logic [EVENT_CNT_WIDTH-1:0] EVENT_CNT,
    output logic [7:0]                 ID_ERR_CNT,
    output logic                       ID_ERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [2:0]                 r_w;
    logic [2:0]                 w_w_nxt;
    logic [1:0]                 r_k;
    logic [1:0]                 w_k_nxt;
    logic [15:0]                r_slot [8];
    logic [EVENT_CNT_WIDTH-1:0] r_event_cnt;

    logic                       w_rd;
    logic                       w_fetch_done;
    logic                       w_event_done;
    logic                       w_valid;
    logic                       w_last;

    // State, word index and output index registers.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_w     <= 3'd0;
            r_k     <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_w     <= w_w_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Next-state logic and handshake decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_w_nxt      = r_w;
        w_k_nxt      = r_k;
        w_rd         = 1'b0;
        w_fetch_done = 1'b0;
        w_event_done = 1'b0;
        w_valid      = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!bus.SRC_EMPTY) begin
                    w_state_nxt = FETCH;
                    w_w_nxt     = 3'd0;
                end
            end
            FETCH: begin
                // Empty FIFO simply stalls with W held.
                w_rd = !bus.SRC_EMPTY;
                if (w_rd) begin
                    w_w_nxt = r_w + 3'd1;
                    if (r_w == 3'd7) begin
                        w_state_nxt  = SEND;
                        w_fetch_done = 1'b1;
                        w_k_nxt      = 2'd0;
                    end
                end
            end
            SEND: begin
                w_valid = 1'b1;
                w_last  = (r_k == 2'd3);
                if (bus.OUT_READY) begin
                    w_k_nxt = r_k + 2'd1;
                    if (r_k == 2'd3) begin
                        w_state_nxt  = IDLE;
                        w_event_done = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Event buffer: one 16-bit slot per upstream word.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) begin
                r_slot[i] <= 16'd0;
            end
        end else if (w_rd) begin
            r_slot[r_w] <= bus.SRC_DATA;
        end
    end

    // Delivered-event counter, saturating.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            r_event_cnt <= '0;
        end else if (w_event_done && (r_event_cnt != '1)) begin
            r_event_cnt <= r_event_cnt + 1'b1;
        end
    end

    assign bus.SRC_READ  = w_rd;
    assign bus.OUT_VALID = w_valid;
    assign bus.OUT_LAST  = w_last;
    // Zero outside SEND so the bus idles at 0 after reset.
    assign bus.OUT_DATA  = w_valid ? {r_slot[{r_k, 1'b1}], r_slot[{r_k, 1'b0}]} : 32'd0;
    assign EVENT_CNT     = r_event_cnt;

`ifdef TLU_EVENT_PACKER_ID_CHECK_EN
    logic [31:0] r_last_id;
    logic        r_id_valid;
    logic        r_id_err;
    logic [7:0]  r_id_err_cnt;
    logic [31:0] w_trig_id;
    logic        w_id_mismatch;

    // Slot 7 is still on SRC_DATA during the final fetch cycle.
    assign w_trig_id     = {bus.SRC_DATA, r_slot[6]};
    assign w_id_mismatch = r_id_valid && (w_trig_id != (r_last_id + 32'd1));

    // Trigger-ID reference tracking; first event after reset only loads it.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            r_last_id    <= 32'd0;
            r_id_valid   <= 1'b0;
            r_id_err     <= 1'b0;
            r_id_err_cnt <= 8'd0;
        end else begin
            r_id_err <= 1'b0;
            if (w_fetch_done) begin
                r_last_id  <= w_trig_id;
                r_id_valid <= 1'b1;
                if (w_id_mismatch) begin
                    r_id_err <= 1'b1;
                    if (r_id_err_cnt != 8'hff) begin
                        r_id_err_cnt <= r_id_err_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign ID_ERR     = r_id_err;
    assign ID_ERR_CNT = r_id_err_cnt;
`else
    assign ID_ERR     = 1'b0;
    assign ID_ERR_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_tlu_event_packer.sv
// Self-checking bench for tlu_event_packer: an upstream FIFO queue feeds the
// DUT; a queue-based event model predicts the output stream and ID errors.
module tb_tlu_event_packer;

    logic        BUS_CLK = 1'b0;
    logic        RST;
    logic [15:0] EVENT_CNT;
    logic [7:0]  ID_ERR_CNT;
    logic        ID_ERR;

    always #5 BUS_CLK = ~BUS_CLK;

    tlu_event_packer_if bus ();

    tlu_event_packer #(
        .EVENT_CNT_WIDTH(16)
    ) dut (
        .BUS_CLK   (BUS_CLK),
        .RST       (RST),
        .bus       (bus),
        .EVENT_CNT (EVENT_CNT),
        .ID_ERR_CNT(ID_ERR_CNT),
        .ID_ERR    (ID_ERR)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [15:0] src_q[$];
    logic [15:0] cur_ev[$];
    logic [32:0] exp_q[$];
    logic [32:0] log_q[$];
    int          first_acc_cyc[$];
    int          m_events;
    int          m_k;
    int          m_errs;
    int          m_pulses;
    bit          exp_pulse;
    bit          ref_valid;
    logic [31:0] ref_id;
    int          stall_pct = 0;
    int          nrdy_pct  = 0;
    bit          force_stall = 0;
    bit          force_nrdy  = 0;
    bit          prev_v, prev_r, prev_l;
    logic [31:0] prev_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // All eight words of an event are in: predict its four output words and ID check.
    task automatic finish_event();
        logic [31:0] trig;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({(k == 3), cur_ev[2*k+1], cur_ev[2*k]});
        end
        trig = {cur_ev[7], cur_ev[6]};
`ifdef TLU_EVENT_PACKER_ID_CHECK_EN
        if (ref_valid && (trig != ref_id + 32'd1)) begin
            exp_pulse = 1'b1;
            if (m_errs < 255) m_errs++;
        end
        ref_valid = 1'b1;
        ref_id    = trig;
`endif
        cur_ev.delete();
    endtask

    task automatic check_cycle();
        logic [32:0] e;
        chk("src_read_while_empty", 64'(bus.SRC_READ & bus.SRC_EMPTY), 0);
        chk("src_read_while_sending", 64'(bus.SRC_READ & bus.OUT_VALID), 0);
        if (!bus.OUT_VALID) chk("last_without_valid", 64'(bus.OUT_LAST), 0);
        if (prev_v && !prev_r) begin
            chk("hold_valid", 64'(bus.OUT_VALID), 1);
            chk("hold_data", 64'(bus.OUT_DATA), 64'(prev_d));
            chk("hold_last", 64'(bus.OUT_LAST), 64'(prev_l));
        end
        chk("event_cnt", 64'(EVENT_CNT), 64'(m_events));
        chk("id_err", 64'(ID_ERR), 64'(exp_pulse));
        chk("id_err_cnt", 64'(ID_ERR_CNT), 64'(m_errs));
        if (ID_ERR) m_pulses++;
        exp_pulse = 1'b0;
        if (bus.SRC_READ) begin
            if (src_q.size() == 0) begin
                fail_now("read_from_empty_model");
            end else begin
                cur_ev.push_back(src_q.pop_front());
                if (cur_ev.size() == 8) finish_event();
            end
        end
        if (bus.OUT_VALID && bus.OUT_READY) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_out_word");
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 64'(bus.OUT_DATA), 64'(e[31:0]));
                chk("out_last", 64'(bus.OUT_LAST), 64'(e[32]));
                log_q.push_back({bus.OUT_LAST, bus.OUT_DATA});
                if (m_k == 0) first_acc_cyc.push_back(cyc);
                if (e[32]) begin
                    if (m_events < 65535) m_events++;
                    m_k = 0;
                end else begin
                    m_k++;
                end
            end
        end
        prev_v = bus.OUT_VALID;
        prev_r = bus.OUT_READY;
        prev_d = bus.OUT_DATA;
        prev_l = bus.OUT_LAST;
    endtask

    // Drive inputs on the falling edge, sample 1 time unit later.
    task automatic step();
        @(negedge BUS_CLK);
        cyc++;
        bus.SRC_EMPTY = (src_q.size() == 0) || force_stall ||
                        (int'($urandom_range(99)) < stall_pct);
        bus.SRC_DATA  = (src_q.size() != 0) ? src_q[0] : 16'($urandom);
        bus.OUT_READY = !force_nrdy && (int'($urandom_range(99)) >= nrdy_pct);
        #1;
        if (!RST) check_cycle();
        else prev_v = 1'b0;
    endtask

    task automatic do_reset();
        src_q.delete();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        cur_ev.delete();
        exp_q.delete();
        log_q.delete();
        first_acc_cyc.delete();
        m_events  = 0;
        m_k       = 0;
        m_errs    = 0;
        m_pulses  = 0;
        exp_pulse = 1'b0;
        ref_valid = 1'b0;
        ref_id    = 32'd0;
        prev_v    = 1'b0;
    endtask

    task automatic push_ev(input logic [31:0] le, input logic [63:0] ts, input logic [31:0] trig);
        src_q.push_back(le[15:0]);
        src_q.push_back(le[31:16]);
        src_q.push_back(ts[15:0]);
        src_q.push_back(ts[31:16]);
        src_q.push_back(ts[47:32]);
        src_q.push_back(ts[63:48]);
        src_q.push_back(trig[15:0]);
        src_q.push_back(trig[31:16]);
    endtask

    // Run until the model has seen n events delivered, then one more cycle for EVENT_CNT.
    task automatic run_events(input int n, input int budget);
        int b = 0;
        while (m_events < n && b < budget) begin
            step();
            b++;
        end
        if (m_events < n) fail_now("timeout_waiting_for_events");
        step();
    endtask

    task automatic chk_basic_event(input string tag);
        chk({tag, "_nwords"}, 64'(log_q.size()), 4);
        if (log_q.size() >= 4) begin
            chk({tag, "_w0"}, 64'(log_q[0]), 64'h0_0403_0201);
            chk({tag, "_w1"}, 64'(log_q[1]), 64'h0_0000_0005);
            chk({tag, "_w2"}, 64'(log_q[2]), 64'h0_0000_0000);
            chk({tag, "_w3"}, 64'(log_q[3]), 64'h1_0000_0007);
        end
        chk({tag, "_event_cnt"}, 64'(EVENT_CNT), 1);
    endtask

    initial begin
        int b;
        logic [31:0] trig;
        RST           = 1'b1;
        bus.SRC_EMPTY = 1'b1;
        bus.SRC_DATA  = 16'd0;
        bus.OUT_READY = 1'b0;

        // Reset state
        do_reset();
        step();
        chk("rst_out_valid", 64'(bus.OUT_VALID), 0);
        chk("rst_out_last", 64'(bus.OUT_LAST), 0);
        chk("rst_out_data", 64'(bus.OUT_DATA), 0);
        chk("rst_src_read", 64'(bus.SRC_READ), 0);
        chk("rst_event_cnt", 64'(EVENT_CNT), 0);
        chk("rst_id_err_cnt", 64'(ID_ERR_CNT), 0);
        chk("rst_id_err", 64'(ID_ERR), 0);

        // Single event, ready always high
        push_ev(32'h0403_0201, 64'h5, 32'h7);
        run_events(1, 100);
        chk_basic_event("basic");

        // Back-pressure at output index 1
        do_reset();
        push_ev(32'h0403_0201, 64'h5, 32'h7);
        push_ev(32'h1111_2222, 64'h3333_4444_5555_6666, 32'h8);
        b = 0;
        while (m_k != 1 && b < 100) begin
            step();
            b++;
        end
        if (m_k != 1) fail_now("timeout_waiting_k1");
        force_nrdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_data", 64'(bus.OUT_DATA), 64'h5);
            chk("bp_valid", 64'(bus.OUT_VALID), 1);
            chk("bp_src_read", 64'(bus.SRC_READ), 0);
        end
        force_nrdy = 1'b0;
        run_events(2, 200);
        chk("bp_nwords", 64'(log_q.size()), 8);
        if (log_q.size() >= 2) chk("bp_w1", 64'(log_q[1]), 64'h0_0000_0005);

        // Upstream empty for 3 cycles at W=4
        do_reset();
        push_ev(32'h0403_0201, 64'h5, 32'h7);
        b = 0;
        while (cur_ev.size() != 4 && b < 100) begin
            step();
            b++;
        end
        force_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_src_read", 64'(bus.SRC_READ), 0);
            chk("stall_w_held", 64'(cur_ev.size()), 4);
        end
        force_stall = 1'b0;
        run_events(1, 100);
        chk_basic_event("stall");

        // Reset at W=5 discards the partial event
        do_reset();
        push_ev(32'h0403_0201, 64'h5, 32'h7);
        b = 0;
        while (cur_ev.size() != 5 && b < 100) begin
            step();
            b++;
        end
        chk("midrst_no_output", 64'(log_q.size()), 0);
        do_reset();
        push_ev(32'h0403_0201, 64'h5, 32'h7);
        run_events(1, 100);
        chk_basic_event("midrst");

        // Trigger IDs 1,2,4,5
        do_reset();
        push_ev(32'hA, 64'h10, 32'd1);
        push_ev(32'hB, 64'h20, 32'd2);
        push_ev(32'hC, 64'h30, 32'd4);
        push_ev(32'hD, 64'h40, 32'd5);
        run_events(4, 300);
`ifdef TLU_EVENT_PACKER_ID_CHECK_EN
        chk("id_seq_err_cnt", 64'(ID_ERR_CNT), 1);
        chk("id_seq_pulses", 64'(m_pulses), 1);
`else
        chk("id_seq_err_cnt", 64'(ID_ERR_CNT), 0);
        chk("id_seq_pulses", 64'(m_pulses), 0);
`endif

        // Back-to-back events, 13-cycle period
        do_reset();
        push_ev(32'h0403_0201, 64'h5, 32'h7);
        push_ev(32'hDEAD_BEEF, 64'h0123_4567_89AB_CDEF, 32'h8);
        push_ev(32'hCAFE_F00D, 64'hFEDC_BA98_7654_3210, 32'h9);
        run_events(3, 200);
        chk("b2b_nwords", 64'(log_q.size()), 12);
        chk("b2b_event_cnt", 64'(EVENT_CNT), 3);
        if (first_acc_cyc.size() == 3) begin
            chk("b2b_period_1", 64'(first_acc_cyc[1] - first_acc_cyc[0]), 13);
            chk("b2b_period_2", 64'(first_acc_cyc[2] - first_acc_cyc[1]), 13);
        end else begin
            fail_now("b2b_event_starts");
        end

        // Randomized traffic with stalls, back-pressure and occasional ID jumps
        do_reset();
        stall_pct = 30;
        nrdy_pct  = 30;
        trig = $urandom;
        for (int i = 0; i < 40; i++) begin
            trig = ($urandom_range(7) == 0) ? $urandom : trig + 32'd1;
            push_ev($urandom, {$urandom, $urandom}, trig);
        end
        run_events(40, 8000);
        stall_pct = 0;
        nrdy_pct  = 0;
        chk("rand_nwords", 64'(log_q.size()), 160);
        chk("rand_event_cnt", 64'(EVENT_CNT), 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
